// File: rtl/clock_rate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_rate_ctrl_if
// Description : Signal bundle between the board push-buttons, the speed
//               controller and the CPU clock divider.
//               master : controller side (reads buttons, drives divider)
//               slave  : environment side (drives buttons, reads divider)
// Signals     : btn_faster, btn_slower, btn_default - raw buttons, active-high
//               div_ratio [31:0] - divide ratio to the divider, always >= 1
//               div_rst          - active-high reset strobe to the divider
//               level [2:0]      - current speed level, 0 = fastest
//               at_min / at_max  - level at the fast / slow end of the table
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_rate_ctrl_if;
  logic        btn_faster;
  logic        btn_slower;
  logic        btn_default;
  logic [31:0] div_ratio;
  logic        div_rst;
  logic [2:0]  level;
  logic        at_min;
  logic        at_max;

  modport master (
    input  btn_faster, btn_slower, btn_default,
    output div_ratio, div_rst, level, at_min, at_max
  );

  modport slave (
    output btn_faster, btn_slower, btn_default,
    input  div_ratio, div_rst, level, at_min, at_max
  );
endinterface
`default_nettype wire

// File: rtl/clock_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_rate_ctrl
// Description : Run-time speed selector for the CPU clock divider. Debounces
//               three raw buttons (faster / slower / default), steps a speed
//               level through a power-of-two ratio table and strobes the
//               divider's reset for two cycles on every ratio change so the
//               divider never keeps counting toward a stale, larger ratio.
// Ports       : clock - system clock
//               reset - asynchronous, active-high
//               bus   - clock_rate_ctrl_if.master (buttons in, divider out)
// Revision    : 1.0 - initial release
// ============================================================================
module clock_rate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RATIO_BASE      = 1,
  parameter int STEP_SHIFT      = 3,
  parameter int N_LEVELS        = 8,
  parameter int RESET_LEVEL     = 4
) (
  input  logic               clock,
  input  logic               reset,
  clock_rate_ctrl_if.master  bus
);

  localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       LVL_RESET = 3'(RESET_LEVEL);
  localparam logic [2:0]       LVL_MAX   = 3'(N_LEVELS - 1);

  // Ratio table entry for a level, computed as a plain 32-bit shift.
  function automatic logic [31:0] ratio_of(input logic [2:0] lvl);
    ratio_of = 32'(RATIO_BASE) << (STEP_SHIFT * int'(lvl));
  endfunction

  // --------------------------------------------------------------------------
  // Input path: synchronizer, debounce and press detection per button.
  // Bit order: 0 = faster, 1 = slower, 2 = default.
  // --------------------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {bus.btn_default, bus.btn_slower, bus.btn_faster};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1;
      logic             sync2;
      logic             stable;
      logic             stable_d;
      logic             pulse;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1    <= 1'b0;
          sync2    <= 1'b0;
          stable   <= 1'b0;
          stable_d <= 1'b0;
          pulse    <= 1'b0;
          cnt      <= '0;
        end else begin
          sync1    <= btn_raw[gi];
          sync2    <= sync1;
          stable_d <= stable;
          // Only a rising edge of the debounced level is an event.
          pulse    <= stable & ~stable_d;
          if (sync2 == stable) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign press[gi] = pulse;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Level FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  level_r, level_nx;
  logic [31:0] ratio_r, ratio_nx;
  logic        rst_r, rst_nx;
  logic        min_r, max_r;
  logic [2:0]  target;

  // Arbitration default > slower > faster; the lower-priority events are
  // simply discarded. Saturation makes an out-of-range step a no-op.
  always_comb begin
    target = level_r;
    if (press[2]) begin
      target = LVL_RESET;
    end else if (press[1]) begin
      target = (level_r == LVL_MAX) ? level_r : level_r + 3'd1;
    end else if (press[0]) begin
      target = (level_r == 3'd0) ? level_r : level_r - 3'd1;
    end
  end

  always_comb begin
    state_nx = state;
    level_nx = level_r;
    ratio_nx = ratio_r;
    rst_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (target != level_r) begin
          state_nx = APPLY;
          level_nx = target;
          ratio_nx = ratio_of(target);
          rst_nx   = 1'b1;
        end
      end
      APPLY: begin
        state_nx = SETTLE;
        rst_nx   = 1'b1;
      end
      SETTLE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      level_r <= LVL_RESET;
      ratio_r <= ratio_of(LVL_RESET);
      rst_r   <= 1'b1;
      min_r   <= (LVL_RESET == 3'd0);
      max_r   <= (LVL_RESET == LVL_MAX);
    end else begin
      state   <= state_nx;
      level_r <= level_nx;
      ratio_r <= ratio_nx;
      rst_r   <= rst_nx;
      min_r   <= (level_nx == 3'd0);
      max_r   <= (level_nx == LVL_MAX);
    end
  end

  assign bus.level     = level_r;
  assign bus.div_ratio = ratio_r;
  assign bus.div_rst   = rst_r;
  assign bus.at_min    = min_r;
  assign bus.at_max    = max_r;

endmodule
`default_nettype wire

// File: tb/tb_clock_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_rate_ctrl
// Description : Self-checking bench for clock_rate_ctrl (DEBOUNCE_CYCLES=4).
//               Expected level/ratio come from a saturating-arithmetic model
//               of the speed table; button timing is randomized.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_rate_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  clock_rate_ctrl_if bus ();

  clock_rate_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int exp_level;

  // Table value: base 1, each level multiplies by 8.
  function automatic logic [31:0] model_ratio(input int l);
    logic [31:0] r;
    r = 32'd1;
    for (int k = 0; k < l; k++) r = r * 32'd8;
    return r;
  endfunction

  function automatic int model_next(input int l, input bit f, input bit s, input bit d);
    if (d) return 4;
    if (s) return (l < 7) ? l + 1 : l;
    if (f) return (l > 0) ? l - 1 : l;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".level"},  32'(bus.level),  32'(exp_level));
    chk({tag, ".ratio"},  bus.div_ratio,   model_ratio(exp_level));
    chk({tag, ".at_min"}, 32'(bus.at_min), 32'(exp_level == 0));
    chk({tag, ".at_max"}, 32'(bus.at_max), 32'(exp_level == 7));
  endtask

  // Drives each button high over [start, start+hold); the slower button
  // toggles every 2 cycles during its first 'bounce' cycles. Counts div_rst
  // high cycles and the first cycle at which level leaves its entry value.
  task automatic run(input int sf, input int hf, input int ss, input int hs,
                     input int sd, input int hd, input int bounce, input int ncyc,
                     output int rst_cnt, output int change_at);
    int prev;
    prev      = exp_level;
    rst_cnt   = 0;
    change_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      bus.btn_faster  = (c >= sf && c < sf + hf);
      bus.btn_slower  = (c >= ss && c < ss + hs) &&
                        !(c < ss + bounce && ((c - ss) / 2) % 2 == 1);
      bus.btn_default = (c >= sd && c < sd + hd);
      @(posedge clock);
      #1;
      if (bus.div_rst === 1'b1) rst_cnt++;
      if (change_at < 0 && bus.level !== 3'(prev)) change_at = c + 1;
    end
    bus.btn_faster  = 1'b0;
    bus.btn_slower  = 1'b0;
    bus.btn_default = 1'b0;
  endtask

  task automatic press_one(input int which, input string tag);
    int hold, gap, rc, ca, nl;
    hold = int'($urandom_range(8, 20));
    gap  = int'($urandom_range(10, 16));
    nl   = model_next(exp_level, which == 0, which == 1, which == 2);
    run(0, (which == 0) ? hold : 0, 0, (which == 1) ? hold : 0,
        0, (which == 2) ? hold : 0, 0, hold + gap, rc, ca);
    chk({tag, ".rst_cycles"}, 32'(rc), (nl != exp_level) ? 32'd2 : 32'd0);
    if (nl != exp_level) chk({tag, ".latency"}, 32'(ca), 32'd8);
    exp_level = nl;
    chk_state(tag);
  endtask

  initial begin
    int rc, ca;
    bus.btn_faster  = 1'b0;
    bus.btn_slower  = 1'b0;
    bus.btn_default = 1'b0;
    reset     = 1'b1;
    exp_level = 4;

    // Reset values
    #2;
    chk_state("reset");
    chk("reset.div_rst", 32'(bus.div_rst), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("reset.hold_div_rst", 32'(bus.div_rst), 32'd1);
    reset = 1'b0;
    #3;
    chk("release.pre_edge", 32'(bus.div_rst), 32'd1);
    @(posedge clock);
    #1;
    chk("release.first_edge", 32'(bus.div_rst), 32'd0);
    chk_state("release");

    // Clean faster press held 20 cycles: one event, fixed latency
    run(0, 20, 0, 0, 0, 0, 0, 30, rc, ca);
    exp_level = model_next(exp_level, 1, 0, 0);
    chk("faster.rst_cycles", 32'(rc), 32'd2);
    chk("faster.latency", 32'(ca), 32'd8);
    chk_state("faster");

    // Back to the default level
    press_one(2, "default");

    // Bouncing slower for 12 cycles, then stable high
    run(0, 0, 0, 24, 0, 0, 12, 34, rc, ca);
    exp_level = model_next(exp_level, 0, 1, 0);
    chk("bounce.rst_cycles", 32'(rc), 32'd2);
    chk("bounce.latency", 32'(ca), 32'd20);
    chk_state("bounce");

    // Walk down to level 0 and push past it
    for (int k = 0; k < 8 && exp_level > 0; k++) press_one(0, "down");
    press_one(0, "sat_min");

    // Walk up to level 7 and push past it
    for (int k = 0; k < 8 && exp_level < 7; k++) press_one(1, "up");
    press_one(1, "sat_max");

    // Level 6, then default+faster together, slower landing in SETTLE
    press_one(0, "to6");
    run(0, 10, 2, 10, 0, 10, 0, 30, rc, ca);
    exp_level = model_next(exp_level, 1, 0, 1);
    chk("simul.rst_cycles", 32'(rc), 32'd2);
    chk_state("simul");

    // Reset while in APPLY at level 2
    press_one(0, "to3");
    bus.btn_faster = 1'b1;
    repeat (8) begin
      @(posedge clock);
      #1;
    end
    exp_level = 2;
    chk_state("apply");
    chk("apply.div_rst", 32'(bus.div_rst), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_level = 4;
    chk_state("midreset");
    chk("midreset.div_rst", 32'(bus.div_rst), 32'd1);
    bus.btn_faster = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midreset.release", 32'(bus.div_rst), 32'd0);
    run(0, 0, 0, 0, 0, 0, 0, 15, rc, ca);
    chk("midreset.quiet", 32'(rc), 32'd0);
    chk_state("midreset.after");

    // Randomized press sequence against the model
    for (int k = 0; k < 12; k++) press_one(int'($urandom_range(0, 2)), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
